instr_stream_encoder: RTL and testbench
=======================================

# instr_stream_encoder

Encoder and loader for the LEGv8 subset decoded by the CPU control unit: ADD, SUB, AND, ORR, LDUR, STUR and CBZ. A host or test harness issues a start command with a base address and an op count, then streams compact op descriptors over a valid/ready handshake. The block encodes each descriptor into a 32-bit instruction word and writes it into instruction memory at consecutive word addresses. It is the write-side counterpart of instruction fetch/decode and is used for program loading and self-checking tests.

## Interface
- ADDR_W, 32, byte-address width of the instruction memory write port
- CNT_W, 16, width of op count and error index
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle command pulse; honoured in IDLE, DONE and ERR, ignored in RUN
- base_addr  in  ADDR_W  byte address of the first word; sampled on start
- op_count  in  CNT_W  number of ops to load; sampled on start
- in_valid  in  1  descriptor valid
- in_ready  out  1  descriptor accepted when in_valid && in_ready
- in_op  in  3  0 ADD, 1 SUB, 2 AND, 3 ORR, 4 LDUR, 5 STUR, 6 CBZ, 7 illegal
- in_rd  in  5  Rd for R-type; Rt for LDUR, STUR and CBZ
- in_rn  in  5  Rn, unused for CBZ
- in_rm  in  5  Rm, R-type only
- in_imm  in  19  signed immediate; DT address for LDUR/STUR, word offset for CBZ
- imem_we  out  1  instruction memory write strobe
- imem_addr  out  ADDR_W  write byte address
- imem_wdata  out  32  encoded instruction
- busy  out  1  high in RUN
- done  out  1  high in DONE
- err  out  1  high in ERR
- err_index  out  CNT_W  zero-based index of the offending op

## Operation
- FSM states: IDLE, RUN, DONE, ERR. Reset enters IDLE.
- On start with op_count=0: go to DONE; no writes are issued.
- On start with op_count>0: go to RUN; the index counter and the address register (base_addr) are loaded.
- in_ready = (state==RUN). It is a combinational function of the state only.
- Encodings:
  - R-type: [31:21] opcode, [20:16] Rm, [15:10] 0, [9:5] Rn, [4:0] Rd.
  - R-type opcodes: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000.
  - D-type: [31:21] opcode (LDUR 11111000010, STUR 11111000000), [20:12] imm[8:0], [11:10] 00, [9:5] Rn, [4:0] Rt.
  - CB: [31:24] 10110100, [23:5] imm[18:0], [4:0] Rt.
- An accepted op is illegal when either condition holds:
  - in_op=7.
  - in_op is LDUR or STUR and imm is outside -256..255, i.e. in_imm[18:8] is not all equal to in_imm[8].
- Legal op:
  - Register the encoded word and the current address.
  - Increment the index; advance the address by 4, wrapping modulo 2^ADDR_W.
  - If this was the last op, go to DONE.
- Illegal op:
  - No write is issued.
  - err_index captures the current index.
  - Go to ERR. ERR persists until start or rst.
- While in_valid is low in RUN, the FSM holds and no write is issued.

## Timing
- Latency is 1 cycle. An op accepted at edge t drives imem_we=1 with its addr and data during cycle t+1 (registered outputs).
- Throughput is 1 op per cycle. imem_we is high for exactly one cycle per legal op.
- The write for the last op coincides with the first cycle of DONE.
- The write for an op accepted just before an illegal op still completes.
- Reset values: in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, busy 0, done 0, err 0, err_index 0.
- rst asserted mid-RUN drops imem_we immediately (asynchronously). A pending write is lost.
- A start in the same cycle as a final accept is ignored because the FSM is still in RUN.

## Structure
- Shared package holds:
  - opcode constants: the 11-bit R/D opcodes and the 8-bit CBZ opcode
  - the 3-bit in_op enum
  - the FSM state enum
- Sub-module instr_word_encode is purely combinational. It maps (op, rd, rn, rm, imm) to a 32-bit word plus an illegal flag. The decoder bench reuses it as a golden model.

## Test plan
- base 0x100, count 1, ADD rd=1 rn=2 rm=3 -> next cycle imem_we=1, addr 0x100, wdata 0x8B030041, then done=1.
- count 1, LDUR rt=4 rn=5 imm=-8 -> wdata 0xF85F80A4.
- count 1, CBZ rt=7 imm=3 -> wdata 0xB4000067.
- base 0x0, count 4, valid gaps and back-to-back accepts -> exactly 4 writes at 0x0, 0x4, 0x8, 0xC; busy falls and done rises on the cycle of the last write.
- count 3, op 2 is STUR imm=300 -> 2 writes, err=1, err_index=2, in_ready=0, no further writes, done=0; repeat with in_op=7 for the same result.
- rst pulsed mid-RUN -> imem_we=0 immediately, all outputs at reset values; then start with count 0 -> done=1 next cycle, no writes.

Source files
------------

// File: rtl/instr_stream_encoder_pkg.sv
// Shared opcode constants, descriptor op codes and FSM state type for the
// LEGv8 instruction stream encoder.
package instr_stream_encoder_pkg;

  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_ORR  = 3'd3,
    OP_LDUR = 3'd4,
    OP_STUR = 3'd5,
    OP_CBZ  = 3'd6,
    OP_ILL  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  // DT address field is a signed 9-bit value; the upper bits must be a pure sign extension.
  function automatic logic dt_imm_fits(input logic [18:0] imm);
    return (imm[18:8] == {11{imm[8]}});
  endfunction

endpackage

// File: rtl/instr_word_encode.sv
// Combinational mapping of one op descriptor to a 32-bit LEGv8 word plus an
// illegal flag; also usable as a reference model by decode-side benches.
module instr_word_encode
  import instr_stream_encoder_pkg::*;
(
  input  op_e         op_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rn_i,
  input  logic [4:0]  rm_i,
  input  logic [18:0] imm_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  always_comb begin
    word_o    = '0;
    illegal_o = 1'b0;
    case (op_i)
      OP_ADD:  word_o = {OPC_ADD, rm_i, 6'b0, rn_i, rd_i};
      OP_SUB:  word_o = {OPC_SUB, rm_i, 6'b0, rn_i, rd_i};
      OP_AND:  word_o = {OPC_AND, rm_i, 6'b0, rn_i, rd_i};
      OP_ORR:  word_o = {OPC_ORR, rm_i, 6'b0, rn_i, rd_i};
      OP_LDUR: begin
        word_o    = {OPC_LDUR, imm_i[8:0], 2'b00, rn_i, rd_i};
        illegal_o = !dt_imm_fits(imm_i);
      end
      OP_STUR: begin
        word_o    = {OPC_STUR, imm_i[8:0], 2'b00, rn_i, rd_i};
        illegal_o = !dt_imm_fits(imm_i);
      end
      OP_CBZ:  word_o = {OPC_CBZ, imm_i, rd_i};
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_stream_encoder.sv
// Streams op descriptors into instruction memory: one encoded word per legal
// op at consecutive word addresses, stopping on the first illegal op.
module instr_stream_encoder
  import instr_stream_encoder_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  op_count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rn,
  input  logic [4:0]        in_rm,
  input  logic [18:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  err_index,
  output state_e            dbg_state
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [CNT_W-1:0]  err_index_q, err_index_d;

  logic [31:0]       enc_word;
  logic              enc_illegal;

  instr_word_encode u_encode (
    .op_i      (op_e'(in_op)),
    .rd_i      (in_rd),
    .rn_i      (in_rn),
    .rm_i      (in_rm),
    .imm_i     (in_imm),
    .word_o    (enc_word),
    .illegal_o (enc_illegal)
  );

  // Handshake: a descriptor transfers on a rising edge where in_valid && in_ready.
  // in_ready depends on state only, so the producer may hold in_valid
  // indefinitely and the encoder never stalls an accepted op.
  assign in_ready = (state_q == ST_RUN);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    err_index_d = err_index_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          cnt_d       = op_count;
          idx_d       = '0;
          addr_d      = base_addr;
          err_index_d = '0;
          state_d     = (op_count == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (in_valid) begin
          if (enc_illegal) begin
            err_index_d = idx_q;
            state_d     = ST_ERR;
          end else begin
            we_d    = 1'b1;
            waddr_d = addr_q;
            wdata_d = enc_word;
            idx_d   = idx_q + CNT_W'(1);
            addr_d  = addr_q + ADDR_W'(4);
            if (idx_q == cnt_q - CNT_W'(1)) state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      err_index_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      err_index_q <= err_index_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = waddr_q;
  assign imem_wdata = wdata_q;
  assign busy       = (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);
  assign err        = (state_q == ST_ERR);
  assign err_index  = err_index_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Directed bench for instr_stream_encoder: table of single-op encodings plus
// hand-written burst, wrap, error, start-collision and reset sequences.
module tb_instr_stream_encoder;
  import instr_stream_encoder_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] op_count;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [4:0]  in_rd, in_rn, in_rm;
  logic [18:0] in_imm;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        busy, done, err;
  logic [15:0] err_index;
  state_e      dbg_state;

  instr_stream_encoder #(.ADDR_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .op_count(op_count),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
    .in_rn(in_rn), .in_rm(in_rm), .in_imm(in_imm), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .busy(busy), .done(done),
    .err(err), .err_index(err_index), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  int check_cnt = 0;
  int pass_cnt  = 0;
  int wr_cnt    = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  // scoreboard: every write strobe must match the head of the expected queue
  always @(negedge clk) begin
    if (!rst && imem_we) begin
      logic [63:0] e;
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check_cnt++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, required no write", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", {32'h0, imem_addr}, {32'h0, e[63:32]});
        check("write_data", {32'h0, imem_wdata}, {32'h0, e[31:0]});
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic start_run(input logic [31:0] b, input logic [15:0] n);
    start = 1'b1;
    base_addr = b;
    op_count = n;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rn,
                      input logic [4:0] rm, input logic [18:0] imm, input int gap);
    int n;
    in_valid = 1'b0;
    in_op = 3'd7;
    repeat (gap) tick();
    in_op = op; in_rd = rd; in_rn = rn; in_rm = rm; in_imm = imm;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      check_cnt++;
      $display("FAIL send_timeout: in_ready 0 after 20 cycles, required 1");
    end else begin
      tick();
    end
    in_valid = 1'b0;
  endtask

  typedef struct packed {
    logic [2:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic [18:0] imm;
    logic [31:0] word;
    logic        ill;
  } vec_t;

  vec_t vecs[12];

  task automatic run_err(input logic [2:0] bad_op, input logic [18:0] bad_imm, input string tag);
    int w0;
    w0 = wr_cnt;
    start_run(32'h200, 16'd3);
    expect_wr(32'h200, 32'h8B030041);
    expect_wr(32'h204, 32'hCB1F001F);
    send(3'd0, 5'd1, 5'd2, 5'd3, 19'h0, 0);
    send(3'd1, 5'd31, 5'd0, 5'd31, 19'h0, 0);
    send(bad_op, 5'd2, 5'd3, 5'd4, bad_imm, 0);
    check({tag, "_err"}, {63'h0, err}, 64'd1);
    check({tag, "_err_index"}, {48'h0, err_index}, 64'd2);
    check({tag, "_in_ready"}, {63'h0, in_ready}, 64'd0);
    check({tag, "_done"}, {63'h0, done}, 64'd0);
    in_op = 3'd0; in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    check({tag, "_write_count"}, 64'(wr_cnt - w0), 64'd2);
    check({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_err_held"}, {63'h0, err}, 64'd1);
  endtask

  initial begin
    int w0;
    vecs[0]  = '{op: 3'd0, rd: 5'd1,  rn: 5'd2,  rm: 5'd3,  imm: 19'h7FFFF, word: 32'h8B030041, ill: 1'b0};
    vecs[1]  = '{op: 3'd1, rd: 5'd31, rn: 5'd0,  rm: 5'd31, imm: 19'h0,     word: 32'hCB1F001F, ill: 1'b0};
    vecs[2]  = '{op: 3'd2, rd: 5'd5,  rn: 5'd6,  rm: 5'd7,  imm: 19'h0,     word: 32'h8A0700C5, ill: 1'b0};
    vecs[3]  = '{op: 3'd3, rd: 5'd9,  rn: 5'd10, rm: 5'd11, imm: 19'h0,     word: 32'hAA0B0149, ill: 1'b0};
    vecs[4]  = '{op: 3'd4, rd: 5'd4,  rn: 5'd5,  rm: 5'd31, imm: 19'h7FFF8, word: 32'hF85F80A4, ill: 1'b0};
    vecs[5]  = '{op: 3'd5, rd: 5'd2,  rn: 5'd3,  rm: 5'd0,  imm: 19'h000FF, word: 32'hF80FF062, ill: 1'b0};
    vecs[6]  = '{op: 3'd4, rd: 5'd0,  rn: 5'd1,  rm: 5'd0,  imm: 19'h7FF00, word: 32'hF8500020, ill: 1'b0};
    vecs[7]  = '{op: 3'd6, rd: 5'd7,  rn: 5'd9,  rm: 5'd9,  imm: 19'h00003, word: 32'hB4000067, ill: 1'b0};
    vecs[8]  = '{op: 3'd6, rd: 5'd1,  rn: 5'd0,  rm: 5'd0,  imm: 19'h7FFFF, word: 32'hB4FFFFE1, ill: 1'b0};
    vecs[9]  = '{op: 3'd5, rd: 5'd1,  rn: 5'd1,  rm: 5'd0,  imm: 19'h00100, word: 32'h0,        ill: 1'b1};
    vecs[10] = '{op: 3'd4, rd: 5'd1,  rn: 5'd1,  rm: 5'd0,  imm: 19'h7FEFF, word: 32'h0,        ill: 1'b1};
    vecs[11] = '{op: 3'd7, rd: 5'd1,  rn: 5'd2,  rm: 5'd3,  imm: 19'h0,     word: 32'h0,        ill: 1'b1};

    rst = 1'b1; start = 1'b0; base_addr = '0; op_count = '0; in_valid = 1'b0;
    in_op = '0; in_rd = '0; in_rn = '0; in_rm = '0; in_imm = '0;
    repeat (2) tick();
    check("rst_in_ready", {63'h0, in_ready}, 64'd0);
    check("rst_imem_we", {63'h0, imem_we}, 64'd0);
    check("rst_imem_addr", {32'h0, imem_addr}, 64'd0);
    check("rst_imem_wdata", {32'h0, imem_wdata}, 64'd0);
    check("rst_flags", {61'h0, busy, done, err}, 64'd0);
    check("rst_err_index", {48'h0, err_index}, 64'd0);
    rst = 1'b0;
    tick();

    // single-op encodings, each as a count-1 run
    for (int i = 0; i < 12; i++) begin
      logic [31:0] b;
      b = 32'h100 + 32'(i) * 32'h10;
      start_run(b, 16'd1);
      if (!vecs[i].ill) expect_wr(b, vecs[i].word);
      send(vecs[i].op, vecs[i].rd, vecs[i].rn, vecs[i].rm, vecs[i].imm, 0);
      check($sformatf("vec%0d_done", i), {63'h0, done}, {63'h0, !vecs[i].ill});
      check($sformatf("vec%0d_err", i), {63'h0, err}, {63'h0, vecs[i].ill});
      check($sformatf("vec%0d_busy", i), {63'h0, busy}, 64'd0);
      if (vecs[i].ill) check($sformatf("vec%0d_err_index", i), {48'h0, err_index}, 64'd0);
      repeat (2) tick();
      check($sformatf("vec%0d_drain", i), 64'(exp_q.size()), 64'd0);
    end

    // four ops with valid gaps and back-to-back accepts
    w0 = wr_cnt;
    start_run(32'h0, 16'd4);
    expect_wr(32'h0, 32'h8B030041);
    expect_wr(32'h4, 32'hCB1F001F);
    expect_wr(32'h8, 32'h8A0700C5);
    expect_wr(32'hC, 32'hAA0B0149);
    send(3'd0, 5'd1, 5'd2, 5'd3, 19'h0, 0);
    send(3'd1, 5'd31, 5'd0, 5'd31, 19'h0, 2);
    send(3'd2, 5'd5, 5'd6, 5'd7, 19'h0, 0);
    check("burst_busy_mid", {62'h0, busy, done}, 64'b10);
    send(3'd3, 5'd9, 5'd10, 5'd11, 19'h0, 1);
    check("burst_last_flags", {61'h0, busy, done, imem_we}, 64'b011);
    repeat (3) tick();
    check("burst_write_count", 64'(wr_cnt - w0), 64'd4);
    check("burst_drain", 64'(exp_q.size()), 64'd0);

    // address wraps modulo 2^32
    start_run(32'hFFFF_FFFC, 16'd2);
    expect_wr(32'hFFFF_FFFC, 32'hB4000067);
    expect_wr(32'h0, 32'h8B030041);
    send(3'd6, 5'd7, 5'd0, 5'd0, 19'h3, 0);
    send(3'd0, 5'd1, 5'd2, 5'd3, 19'h0, 0);
    tick();
    check("wrap_drain", 64'(exp_q.size()), 64'd0);

    run_err(3'd5, 19'h12C, "err_stur");
    run_err(3'd7, 19'h0, "err_op7");

    // start during the final accept is ignored
    start_run(32'h300, 16'd1);
    expect_wr(32'h300, 32'hB4000067);
    in_op = 3'd6; in_rd = 5'd7; in_imm = 19'h3; in_valid = 1'b1;
    start = 1'b1; base_addr = 32'h400; op_count = 16'd2;
    tick();
    in_valid = 1'b0; start = 1'b0;
    check("collide_state", {62'h0, busy, done}, 64'b01);
    tick();
    check("collide_hold", {62'h0, busy, done}, 64'b01);
    check("collide_drain", 64'(exp_q.size()), 64'd0);

    // asynchronous reset in the middle of a run drops the pending write
    start_run(32'h500, 16'd3);
    send(3'd0, 5'd1, 5'd2, 5'd3, 19'h0, 0);
    #1 rst = 1'b1;
    #1;
    check("arst_imem_we", {63'h0, imem_we}, 64'd0);
    check("arst_imem_addr", {32'h0, imem_addr}, 64'd0);
    check("arst_imem_wdata", {32'h0, imem_wdata}, 64'd0);
    check("arst_flags", {60'h0, in_ready, busy, done, err}, 64'd0);
    check("arst_err_index", {48'h0, err_index}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    w0 = wr_cnt;
    start_run(32'h600, 16'd0);
    check("count0_flags", {61'h0, busy, done, imem_we}, 64'b010);
    repeat (2) tick();
    check("count0_no_write", 64'(wr_cnt - w0), 64'd0);
    check("final_drain", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
